// File: rtl/bch_gather_pkg.sv
// ============================================================================
// Module  : bch_gather_pkg
// Purpose : Shared types and beat-count helpers for the syndrome gather stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bch_gather_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Beats needed to carry syn_w bits at bits per beat (rounded up).
  function automatic int calc_nbeats(input int syn_w, input int bits);
    return (syn_w + bits - 1) / bits;
  endfunction

  function automatic int calc_cw(input int nbeats);
    return $clog2(nbeats + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bch_syndrome_gather.sv
// ============================================================================
// Module  : bch_syndrome_gather
// Purpose : Assembles the serial syndrome stream into one vector per codeword,
//           checks first/last framing and hands the vector downstream.
//           Optional error-frame counter enabled by BCH_GATHER_ERRCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bch_syndrome_gather
  import bch_gather_pkg::*;
#(
  parameter int M    = 5,
  parameter int T    = 3,
  parameter int BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [BITS-1:0]     in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [T*M-1:0]      syndromes,
  output logic                err_present,
  output logic                frame_err
`ifdef BCH_GATHER_ERRCNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int SYN_W  = T * M;
  localparam int NBEATS = calc_nbeats(SYN_W, BITS);
  localparam int CW     = calc_cw(NBEATS);
  localparam int VEC_W  = NBEATS * BITS;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              err_q, err_d;
  logic              ferr_q, ferr_d;

  logic              accept;
  logic [CW-1:0]     idx;
  logic [VEC_W-1:0]  wr_vec;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ferr_d  = 1'b0;
    idx     = '0;
    wr_vec  = vec_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (!in_first && (state_q == IDLE)) begin
            ferr_d = 1'b1;
          end else begin
            // A first marker always opens a fresh frame; mid-frame it is a restart.
            if (in_first) begin
              idx    = '0;
              wr_vec = '0;
              ferr_d = (state_q == COLLECT);
            end else begin
              idx    = count_q;
            end
            for (int k = 0; k < NBEATS; k++) begin
              if (idx == CW'(k)) wr_vec[k*BITS +: BITS] = in_data;
            end
            vec_d = wr_vec;

            if ((idx == LAST_IDX) && in_last) begin
              state_d = HOLD;
              count_d = idx + CW'(1);
              err_d   = |wr_vec[SYN_W-1:0];
            end else if (in_last || (idx == LAST_IDX)) begin
              ferr_d  = 1'b1;
              state_d = IDLE;
              count_d = '0;
            end else begin
              state_d = COLLECT;
              count_d = idx + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign out_valid   = (state_q == HOLD);
  assign syndromes   = vec_q[SYN_W-1:0];
  assign err_present = err_q;
  assign frame_err   = ferr_q;

`ifdef BCH_GATHER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Counts delivered frames that carry errors; sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q == HOLD) && out_ready && err_q && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 16'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bch_syndrome_gather.sv
// ============================================================================
// Module  : tb_bch_syndrome_gather
// Purpose : Self-checking bench for bch_syndrome_gather (M=5, T=3, BITS=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bch_syndrome_gather;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_first, in_last;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, out_ready;
  logic [14:0] syndromes;
  logic        err_present, frame_err;
`ifdef BCH_GATHER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad   = 0;
  int ferr_seen = 0;
  int exp_cnt = 0;

  bch_syndrome_gather #(.M(5), .T(3), .BITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .syndromes   (syndromes),
    .err_present (err_present),
    .frame_err   (frame_err)
`ifdef BCH_GATHER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

  // Beat k occupies bit positions 4k..4k+3; anything above bit 14 is lost.
  function automatic logic [14:0] model_vec(input logic [3:0] b0, b1, b2, b3);
    int v;
    v = int'(b0) + int'(b1) * 16 + int'(b2) * 256 + int'(b3) * 4096;
    return 15'(v % 32768);
  endfunction

  task automatic drive_beat(input logic f, input logic l, input logic [3:0] d);
    in_valid = 1'b1; in_first = f; in_last = l; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 4'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [3:0] b0, b1, b2, b3, input int maxgap);
    logic [3:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) idle_cycles($urandom_range(0, maxgap));
      drive_beat(k == 0, k == 3, b[k]);
    end
  endtask

  task automatic handshake(input int waitc, input logic [14:0] v);
    idle_cycles(waitc);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (v != 15'd0) exp_cnt++;
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (syndromes !== 15'd0) begin bad++; $display("FAIL reset_syndromes: got %h want 0", syndromes); end
    total++; if (err_present !== 1'b0) begin bad++; $display("FAIL reset_err_present: got %b want 0", err_present); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_clean;
    int f0;
    logic [14:0] e;
    f0 = ferr_seen;
    e = model_vec(4'h1, 4'h2, 4'h3, 4'hF);
    out_ready = 1'b1;
    drive_beat(1'b1, 1'b0, 4'h1);
    drive_beat(1'b0, 1'b0, 4'h2);
    drive_beat(1'b0, 1'b0, 4'h3);
    drive_beat(1'b0, 1'b1, 4'hF);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clean_out_valid: got %b want 1", out_valid); end
    total++; if (syndromes !== e) begin bad++; $display("FAIL clean_syndromes: got %h want %h", syndromes, e); end
    total++; if (err_present !== 1'b1) begin bad++; $display("FAIL clean_err_present: got %b want 1", err_present); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL clean_after_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    @(negedge clk); #1;
    total++; if (ferr_seen - f0 != 0) begin bad++; $display("FAIL clean_frame_err: got %0d pulses want 0", ferr_seen - f0); end
  endtask

  task automatic test_backpressure;
    int f0;
    f0 = ferr_seen;
    out_ready = 1'b0;
    send_frame(4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_cycle%0d: got valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
      idle_cycles(1);
    end
    total++; if (syndromes !== 15'd0 || err_present !== 1'b0) begin bad++; $display("FAIL bp_zero_vec: got %h err=%b want 0 err=0", syndromes, err_present); end
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_sixth_cycle: got %b want 1", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    total++; if (ferr_seen - f0 != 0) begin bad++; $display("FAIL bp_frame_err: got %0d want 0", ferr_seen - f0); end
`ifdef BCH_GATHER_ERRCNT_EN
    total++; if (err_count !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_err_count: got %0d want %0d", err_count, exp_cnt); end
`endif
  endtask

  task automatic test_stray_beat;
    int f0;
    f0 = ferr_seen;
    drive_beat(1'b0, 1'b0, 4'h5);
    @(negedge clk); #1;
    total++; if (ferr_seen - f0 != 1) begin bad++; $display("FAIL stray_frame_err: got %0d want 1", ferr_seen - f0); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stray_state: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_early_last;
    int f0;
    logic [14:0] e;
    f0 = ferr_seen;
    drive_beat(1'b1, 1'b0, 4'h9);
    drive_beat(1'b0, 1'b0, 4'h8);
    drive_beat(1'b0, 1'b1, 4'h7);
    @(negedge clk); #1;
    total++; if (ferr_seen - f0 != 1) begin bad++; $display("FAIL early_last_frame_err: got %0d want 1", ferr_seen - f0); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL early_last_state: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    idle_cycles(1);
    e = model_vec(4'hC, 4'h0, 4'h5, 4'h6);
    send_frame(4'hC, 4'h0, 4'h5, 4'h6, 1);
    total++; if (out_valid !== 1'b1 || syndromes !== e) begin bad++; $display("FAIL early_last_next: got valid=%b %h want 1 %h", out_valid, syndromes, e); end
    handshake(1, e);
  endtask

  task automatic test_missing_last;
    int f0;
    f0 = ferr_seen;
    drive_beat(1'b1, 1'b0, 4'h1);
    drive_beat(1'b0, 1'b0, 4'h2);
    drive_beat(1'b0, 1'b0, 4'h3);
    drive_beat(1'b0, 1'b0, 4'h4);
    @(negedge clk); #1;
    total++; if (ferr_seen - f0 != 1 || out_valid !== 1'b0) begin bad++; $display("FAIL missing_last: got pulses=%0d valid=%b want 1/0", ferr_seen - f0, out_valid); end
  endtask

  task automatic test_restart;
    int f0;
    logic [14:0] e;
    f0 = ferr_seen;
    e = model_vec(4'hA, 4'h1, 4'h2, 4'h3);
    drive_beat(1'b1, 1'b0, 4'h7);
    drive_beat(1'b0, 1'b0, 4'h8);
    drive_beat(1'b1, 1'b0, 4'hA);
    drive_beat(1'b0, 1'b0, 4'h1);
    drive_beat(1'b0, 1'b0, 4'h2);
    drive_beat(1'b0, 1'b1, 4'h3);
    total++; if (out_valid !== 1'b1 || syndromes !== e) begin bad++; $display("FAIL restart_vec: got valid=%b %h want 1 %h", out_valid, syndromes, e); end
    total++; if (syndromes[3:0] !== 4'hA) begin bad++; $display("FAIL restart_beat0: got %h want a", syndromes[3:0]); end
    total++; if (ferr_seen - f0 != 1) begin bad++; $display("FAIL restart_frame_err: got %0d want 1", ferr_seen - f0); end
    handshake(0, e);
  endtask

  task automatic test_async_reset;
    logic [14:0] e;
    drive_beat(1'b1, 1'b0, 4'h5);
    drive_beat(1'b0, 1'b0, 4'h6);
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (syndromes !== 15'd0 || err_present !== 1'b0) begin bad++; $display("FAIL areset_vec: got %h err=%b want 0/0", syndromes, err_present); end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL areset_ctl: got ready=%b valid=%b ferr=%b want 1/0/0", in_ready, out_valid, frame_err); end
`ifdef BCH_GATHER_ERRCNT_EN
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL areset_err_count: got %0d want 0", err_count); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);
    e = model_vec(4'h3, 4'hE, 4'h0, 4'hB);
    send_frame(4'h3, 4'hE, 4'h0, 4'hB, 2);
    total++; if (out_valid !== 1'b1 || syndromes !== e || err_present !== 1'b1) begin bad++; $display("FAIL areset_next: got valid=%b %h err=%b want 1 %h 1", out_valid, syndromes, err_present, e); end
    handshake(0, e);
  endtask

  task automatic test_random;
    logic [3:0] b [4];
    logic [14:0] e;
    int w;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      e = model_vec(b[0], b[1], b[2], b[3]);
      send_frame(b[0], b[1], b[2], b[3], 3);
      total++; if (out_valid !== 1'b1 || syndromes !== e) begin bad++; $display("FAIL rand%0d_vec: got valid=%b %h want 1 %h", n, out_valid, syndromes, e); end
      total++; if (err_present !== (e != 15'd0)) begin bad++; $display("FAIL rand%0d_err: got %b want %b", n, err_present, e != 15'd0); end
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        idle_cycles(1);
        total++; if (out_valid !== 1'b1 || syndromes !== e) begin bad++; $display("FAIL rand%0d_hold: got valid=%b %h want 1 %h", n, out_valid, syndromes, e); end
      end
      handshake(0, e);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand%0d_release: got %b want 0", n, out_valid); end
      idle_cycles($urandom_range(0, 2));
    end
  endtask

`ifdef BCH_GATHER_ERRCNT_EN
  task automatic test_errcnt;
    rst_n = 1'b0;
    exp_cnt = 0;
    idle_cycles(1);
    rst_n = 1'b1;
    send_frame(4'h1, 4'h0, 4'h0, 4'h0, 0); handshake(0, 15'h0001);
    send_frame(4'h0, 4'h0, 4'h0, 4'h0, 0); handshake(1, 15'h0000);
    send_frame(4'h0, 4'h2, 4'h0, 4'h0, 0); handshake(0, 15'h0020);
    send_frame(4'h0, 4'h0, 4'h0, 4'h7, 0); handshake(2, 15'h7000);
    total++; if (err_count !== 16'd3) begin bad++; $display("FAIL errcnt_three: got %0d want 3", err_count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 4'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    idle_cycles(1);
    test_clean;
    test_backpressure;
    test_stray_beat;
    test_early_last;
    test_missing_last;
    test_restart;
    test_async_reset;
    test_random;
`ifdef BCH_GATHER_ERRCNT_EN
    total++; if (err_count !== 16'(exp_cnt)) begin bad++; $display("FAIL errcnt_model: got %0d want %0d", err_count, exp_cnt); end
    test_errcnt;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
